// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy thresholds, sticky error
// flags, synchronous flush and optional first-word-fall-through output.
module fifo_sync_param #(
    parameter int FIFO_WIDTH = 8,
    parameter int ADDR_SIZE  = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  we,
    input  logic                  re,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_SIZE:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0]   DEPTH_C = DEPTH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0]   AF_C    = AF_LEVEL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0]   AE_C    = AE_LEVEL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0]   CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $fatal(1, "fifo_sync_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [FIFO_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 rd_acc, wr_acc;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A full FIFO can still take a write when the head is popped in the same cycle.
    assign rd_acc = re && !empty;
    assign wr_acc = we && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
            if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
            if (we && !wr_acc) ovf_d = 1'b1;
            if (re && !rd_acc) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && wr_acc) mem[wr_ptr_q] <= data_in;
    end

    if (FWFT) begin : g_fwft
        assign data_out = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] dout_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)         dout_q <= '0;
            else if (flush)  dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rd_ptr_q];
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-mode and an FWFT instance
// share all stimulus; each task checks the instance relevant to its feature.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_cnt, f_cnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .we(we), .re(re),
        .data_in(data_in), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_sync_param #(.FWFT(1'b1)) u_fw (
        .clk(clk), .rst(rst), .flush(flush), .we(we), .re(re),
        .data_in(data_in), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic w, input logic r, input logic [7:0] d);
        we = w; re = r; data_in = d;
        step();
        we = 1'b0; re = 1'b0;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        hard_reset();
        for (int i = 0; i < 6; i++) do_op(1'b1, 1'b0, 8'hC0 + 8'(i));
        do_op(1'b0, 1'b1, 8'h00);
        vecs++; if (s_cnt !== 5'd5) begin errs++; $display("FAIL pre_rst_count got %0d want 5", s_cnt); end
        vecs++; if (s_dout !== 8'hC0) begin errs++; $display("FAIL pre_rst_dout got %h want c0", s_dout); end
        #2 rst = 1'b1;
        #1;
        vecs++; if (s_cnt !== 5'd0) begin errs++; $display("FAIL rst_count got %0d want 0", s_cnt); end
        vecs++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin errs++; $display("FAIL rst_flags got %b want 1100", {s_empty, s_ae, s_full, s_af}); end
        vecs++; if (s_dout !== 8'h00) begin errs++; $display("FAIL rst_dout got %h want 00", s_dout); end
        vecs++; if ({s_ovf, s_unf} !== 2'b00) begin errs++; $display("FAIL rst_err got %b want 00", {s_ovf, s_unf}); end
        vecs++; if (f_dout !== 8'h00 || f_cnt !== 5'd0) begin errs++; $display("FAIL rst_fwft got %h/%0d want 00/0", f_dout, f_cnt); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill_drain();
        hard_reset();
        for (int i = 0; i < 16; i++) begin
            do_op(1'b1, 1'b0, 8'h0A + 8'(i));
            vecs++; if (s_cnt !== 5'(i + 1)) begin errs++; $display("FAIL fill_count[%0d] got %0d want %0d", i, s_cnt, i + 1); end
            vecs++; if (s_ae !== (i + 1 <= 2)) begin errs++; $display("FAIL fill_ae[%0d] got %b want %b", i, s_ae, i + 1 <= 2); end
            vecs++; if (s_af !== (i + 1 >= 14)) begin errs++; $display("FAIL fill_af[%0d] got %b want %b", i, s_af, i + 1 >= 14); end
            vecs++; if (s_full !== (i == 15)) begin errs++; $display("FAIL fill_full[%0d] got %b want %b", i, s_full, i == 15); end
        end
        do_op(1'b1, 1'b0, 8'hFF);
        vecs++; if (s_ovf !== 1'b1) begin errs++; $display("FAIL ovf_set got %b want 1", s_ovf); end
        vecs++; if (s_cnt !== 5'd16) begin errs++; $display("FAIL ovf_count got %0d want 16", s_cnt); end
        for (int i = 0; i < 16; i++) begin
            do_op(1'b0, 1'b1, 8'h00);
            vecs++; if (s_dout !== 8'h0A + 8'(i)) begin errs++; $display("FAIL drain_data[%0d] got %h want %h", i, s_dout, 8'h0A + 8'(i)); end
            vecs++; if (s_cnt !== 5'(15 - i)) begin errs++; $display("FAIL drain_count[%0d] got %0d want %0d", i, s_cnt, 15 - i); end
        end
        vecs++; if (s_empty !== 1'b1 || s_unf !== 1'b0) begin errs++; $display("FAIL drained got empty=%b unf=%b want 1/0", s_empty, s_unf); end
        do_op(1'b0, 1'b1, 8'h00);
        vecs++; if (s_unf !== 1'b1) begin errs++; $display("FAIL unf_set got %b want 1", s_unf); end
        vecs++; if (s_dout !== 8'h19) begin errs++; $display("FAIL unf_hold got %h want 19", s_dout); end
        vecs++; if (s_ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b want 1", s_ovf); end
    endtask

    task automatic test_wrap();
        hard_reset();
        for (int i = 0; i < 12; i++) do_op(1'b1, 1'b0, 8'h80 + 8'(i));
        for (int i = 0; i < 12; i++) do_op(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) do_op(1'b1, 1'b0, 8'h30 + 8'(i));
        vecs++; if (s_cnt !== 5'd10) begin errs++; $display("FAIL wrap_count got %0d want 10", s_cnt); end
        for (int i = 0; i < 10; i++) begin
            do_op(1'b0, 1'b1, 8'h00);
            vecs++; if (s_dout !== 8'h30 + 8'(i)) begin errs++; $display("FAIL wrap_data[%0d] got %h want %h", i, s_dout, 8'h30 + 8'(i)); end
        end
        vecs++; if (s_cnt !== 5'd0 || s_empty !== 1'b1) begin errs++; $display("FAIL wrap_end got %0d/%b want 0/1", s_cnt, s_empty); end
    endtask

    task automatic test_simultaneous();
        hard_reset();
        for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 8'(i));
        do_op(1'b1, 1'b1, 8'hAA);
        vecs++; if (s_cnt !== 5'd16) begin errs++; $display("FAIL full_rw_count got %0d want 16", s_cnt); end
        vecs++; if (s_dout !== 8'h00) begin errs++; $display("FAIL full_rw_head got %h want 00", s_dout); end
        vecs++; if (s_ovf !== 1'b0) begin errs++; $display("FAIL full_rw_ovf got %b want 0", s_ovf); end
        for (int i = 1; i <= 16; i++) begin
            do_op(1'b0, 1'b1, 8'h00);
            vecs++; if (s_dout !== ((i == 16) ? 8'hAA : 8'(i))) begin errs++; $display("FAIL full_rw_data[%0d] got %h want %h", i, s_dout, (i == 16) ? 8'hAA : 8'(i)); end
        end
        do_op(1'b1, 1'b1, 8'h55);
        vecs++; if (s_cnt !== 5'd1) begin errs++; $display("FAIL empty_rw_count got %0d want 1", s_cnt); end
        vecs++; if (s_unf !== 1'b1) begin errs++; $display("FAIL empty_rw_unf got %b want 1", s_unf); end
        do_op(1'b0, 1'b1, 8'h00);
        vecs++; if (s_dout !== 8'h55) begin errs++; $display("FAIL empty_rw_data got %h want 55", s_dout); end
    endtask

    task automatic test_fwft();
        hard_reset();
        vecs++; if (f_dout !== 8'h00 || f_empty !== 1'b1) begin errs++; $display("FAIL fwft_idle got %h/%b want 00/1", f_dout, f_empty); end
        do_op(1'b1, 1'b0, 8'h55);
        vecs++; if (f_dout !== 8'h55) begin errs++; $display("FAIL fwft_first got %h want 55", f_dout); end
        vecs++; if (f_empty !== 1'b0) begin errs++; $display("FAIL fwft_nonempty got %b want 0", f_empty); end
        do_op(1'b1, 1'b0, 8'h66);
        vecs++; if (f_dout !== 8'h55) begin errs++; $display("FAIL fwft_head_hold got %h want 55", f_dout); end
        do_op(1'b0, 1'b1, 8'h00);
        vecs++; if (f_dout !== 8'h66) begin errs++; $display("FAIL fwft_pop1 got %h want 66", f_dout); end
        do_op(1'b0, 1'b1, 8'h00);
        vecs++; if (f_dout !== 8'h00 || f_empty !== 1'b1) begin errs++; $display("FAIL fwft_pop2 got %h/%b want 00/1", f_dout, f_empty); end
    endtask

    task automatic test_flush();
        hard_reset();
        for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 8'h40 + 8'(i));
        do_op(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 7; i++) do_op(1'b0, 1'b1, 8'h00);
        vecs++; if (s_cnt !== 5'd9 || s_ovf !== 1'b1) begin errs++; $display("FAIL pre_flush got %0d/%b want 9/1", s_cnt, s_ovf); end
        vecs++; if (s_dout !== 8'h46) begin errs++; $display("FAIL pre_flush_dout got %h want 46", s_dout); end
        flush = 1'b1;
        do_op(1'b1, 1'b0, 8'hEE);
        flush = 1'b0;
        vecs++; if (s_cnt !== 5'd0 || s_empty !== 1'b1) begin errs++; $display("FAIL flush_count got %0d/%b want 0/1", s_cnt, s_empty); end
        vecs++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin errs++; $display("FAIL flush_err got %b%b want 00", s_ovf, s_unf); end
        vecs++; if (s_dout !== 8'h00 || f_dout !== 8'h00) begin errs++; $display("FAIL flush_dout got %h/%h want 00/00", s_dout, f_dout); end
        vecs++; if ({s_ae, s_af, s_full} !== 3'b100) begin errs++; $display("FAIL flush_flags got %b want 100", {s_ae, s_af, s_full}); end
        do_op(1'b1, 1'b0, 8'h77);
        vecs++; if (s_cnt !== 5'd1 || f_dout !== 8'h77) begin errs++; $display("FAIL post_flush got %0d/%h want 1/77", s_cnt, f_dout); end
        do_op(1'b0, 1'b1, 8'h00);
        vecs++; if (s_dout !== 8'h77 || s_cnt !== 5'd0) begin errs++; $display("FAIL post_flush_rd got %h/%0d want 77/0", s_dout, s_cnt); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
